// File: rtl/mem_bus_sched.sv
// Byte-serial scheduler for the single RAM/IO port shared by icache fetch, SLB load and ROB store.
// Define MEM_SCHED_RR_EN for round-robin LOAD/FETCH arbitration; default is fixed STORE > LOAD > FETCH.
module mem_bus_sched #(
    parameter int LINE_BYTES = 16,
    parameter int CNT_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rb,
    input  logic                    fc_valid,
    input  logic [31:0]             fc_addr,
    output logic                    fc_done,
    output logic [8*LINE_BYTES-1:0] fc_line,
    input  logic                    ld_valid,
    input  logic [31:0]             ld_addr,
    input  logic [3:0]              ld_len,
    output logic                    ld_done,
    output logic [31:0]             ld_data,
    input  logic                    st_valid,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_data,
    input  logic [3:0]              st_len,
    output logic                    st_done,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_e;

    localparam int               BUF_W  = 8 * LINE_BYTES;
    localparam logic [CNT_W-1:0] LINE_N = CNT_W'(LINE_BYTES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      sdata_q, sdata_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BUF_W-1:0] line_q, line_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic             issued_q, issued_d;
    logic             fc_done_q, fc_done_d;
    logic             ld_done_q, ld_done_d;
    logic             st_done_q, st_done_d;

    logic [CNT_W-1:0] cap_idx;
    logic             xfer_active;
    logic             io_blocked;
    logic             pick_load;
    logic [7:0]       st_byte;

`ifdef MEM_SCHED_RR_EN
    logic rr_load_last_q, rr_load_last_d;
    // The requester granted last between LOAD and FETCH loses the next tie.
    assign pick_load = ld_valid && !(fc_valid && rr_load_last_q);
`else
    assign pick_load = ld_valid;
`endif

    assign cap_idx     = cnt_q - ONE;
    assign xfer_active = (state_q != S_IDLE) && (cnt_q != len_q);
    assign io_blocked  = (base_q[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        st_byte = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (cnt_q == CNT_W'(k)) st_byte = sdata_q[8*k +: 8];
        end
    end

    assign mem_a    = xfer_active ? (base_q + {{(32-CNT_W){1'b0}}, cnt_q}) : 32'h0;
    assign mem_wr   = xfer_active && (state_q == S_STORE) && rdy && !io_blocked;
    assign mem_dout = (xfer_active && (state_q == S_STORE)) ? st_byte : 8'h00;

    assign fc_done = fc_done_q;
    assign ld_done = ld_done_q;
    assign st_done = st_done_q;
    assign fc_line = line_q;
    assign ld_data = ld_data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        base_d    = base_q;
        sdata_d   = sdata_q;
        buf_d     = buf_q;
        line_d    = line_q;
        ld_data_d = ld_data_q;
        issued_d  = 1'b0;
        fc_done_d = fc_done_q;
        ld_done_d = ld_done_q;
        st_done_d = st_done_q;
`ifdef MEM_SCHED_RR_EN
        rr_load_last_d = rr_load_last_q;
`endif

        // RAM returns data one cycle after the address, even while frozen, so capture ignores rdy.
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (issued_q && (cap_idx == CNT_W'(i))) buf_d[8*i +: 8] = mem_din;
        end

        if (rdy) begin
            fc_done_d = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (st_valid) begin
                        state_d = S_STORE;
                        base_d  = st_addr;
                        sdata_d = st_data;
                        len_d   = {{(CNT_W-4){1'b0}}, st_len};
                        cnt_d   = '0;
                    end else if (!rb && (ld_valid || fc_valid)) begin
                        state_d = pick_load ? S_LOAD : S_FETCH;
                        base_d  = pick_load ? ld_addr : fc_addr;
                        len_d   = pick_load ? {{(CNT_W-4){1'b0}}, ld_len} : LINE_N;
                        cnt_d   = '0;
`ifdef MEM_SCHED_RR_EN
                        rr_load_last_d = pick_load;
`endif
                    end
                end
                S_FETCH, S_LOAD: begin
                    if (rb) begin
                        state_d = S_IDLE;
                    end else if (cnt_q != len_q) begin
                        cnt_d    = cnt_q + ONE;
                        issued_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        if (state_q == S_FETCH) begin
                            fc_done_d = 1'b1;
                            line_d    = buf_d;
                        end else begin
                            ld_done_d = 1'b1;
                            if (len_q == CNT_W'(1))      ld_data_d = {24'h0, buf_d[7:0]};
                            else if (len_q == CNT_W'(2)) ld_data_d = {16'h0, buf_d[15:0]};
                            else                         ld_data_d = buf_d[31:0];
                        end
                    end
                end
                S_STORE: begin
                    if (cnt_q != len_q) begin
                        if (!io_blocked) cnt_d = cnt_q + ONE;
                    end else begin
                        state_d   = S_IDLE;
                        st_done_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            sdata_q   <= '0;
            buf_q     <= '0;
            line_q    <= '0;
            ld_data_q <= '0;
            issued_q  <= 1'b0;
            fc_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
`ifdef MEM_SCHED_RR_EN
            rr_load_last_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            base_q    <= base_d;
            sdata_q   <= sdata_d;
            buf_q     <= buf_d;
            line_q    <= line_d;
            ld_data_q <= ld_data_d;
            issued_q  <= issued_d;
            fc_done_q <= fc_done_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
`ifdef MEM_SCHED_RR_EN
            rr_load_last_q <= rr_load_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_sched.sv
// Self-checking bench for mem_bus_sched: directed scenarios plus randomized transactions
// checked against a transaction-level byte-array model of memory and a per-edge progress count.
module tb_mem_bus_sched;

   localparam int K_FETCH = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   logic         clk;
   logic         rst;
   logic         rdy;
   logic         rb;
   logic         fc_valid;
   logic [31:0]  fc_addr;
   logic         fc_done;
   logic [127:0] fc_line;
   logic         ld_valid;
   logic [31:0]  ld_addr;
   logic [3:0]   ld_len;
   logic         ld_done;
   logic [31:0]  ld_data;
   logic         st_valid;
   logic [31:0]  st_addr;
   logic [31:0]  st_data;
   logic [3:0]   st_len;
   logic         st_done;
   logic         io_buffer_full;
   logic [7:0]   mem_din;
   logic [7:0]   mem_dout;
   logic [31:0]  mem_a;
   logic         mem_wr;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram     [0:2047];
   logic [7:0] ref_mem [0:2047];
   logic [7:0] io_q    [$];

   mem_bus_sched #(.LINE_BYTES(16), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
      .fc_valid(fc_valid), .fc_addr(fc_addr), .fc_done(fc_done), .fc_line(fc_line),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_len(st_len), .st_done(st_done),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Deterministic initial memory image shared by the environment RAM and the reference model.
   function automatic logic [7:0] initByte(input int a);
      logic [31:0] h;
      if (a >= 32'h100 && a < 32'h110) return 8'(a - 32'h100);
      if (a == 32'h200) return 8'hDE;
      if (a == 32'h201) return 8'hAD;
      if (a == 32'h202) return 8'hBE;
      if (a == 32'h203) return 8'hEF;
      h = a * 37 + 11;
      h = h ^ (h >> 5);
      return h[7:0];
   endfunction

   // Environment RAM: read data appears the cycle after the address; UART writes go to io_q.
   initial begin
      mem_din = 8'h00;
      for (int i = 0; i < 2048; i++) ram[i] = initByte(i);
      forever begin
         @(posedge clk);
         mem_din <= ram[mem_a[10:0]];
         if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) io_q.push_back(mem_dout);
            else ram[mem_a[10:0]] = mem_dout;
         end
      end
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] refLine(input logic [31:0] addr);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[8*i +: 8] = ref_mem[(addr + i) & 32'h7ff];
      return v;
   endfunction

   function automatic logic [31:0] refLoad(input logic [31:0] addr, input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(addr + i) & 32'h7ff];
      return v;
   endfunction

   // One transaction, one requester. Each edge with rdy=1 (and no UART block while bytes remain)
   // advances one byte; n bytes need n+1 such edges after entry before done is visible.
   task automatic applyStimulus(input int kind, input logic [31:0] addr, input int n,
                                input logic [31:0] data, input int stall_pct, input int stall_at,
                                input int io_cycles, output int cycles);
      int          progress;
      int          stall_left;
      int          io_left;
      bit          is_io;
      bit          prod;
      bit          fin;
      logic [31:0] sh;
      logic [10:0] idx;
      progress   = 0;
      stall_left = 3;
      io_left    = io_cycles;
      is_io      = (addr[17:16] == 2'b11);
      cycles     = -1;
      fin        = 1'b0;
      @(negedge clk);
      rdy = 1'b1;
      io_buffer_full = 1'b0;
      case (kind)
         K_FETCH: begin fc_valid = 1'b1; fc_addr = addr; end
         K_LOAD:  begin ld_valid = 1'b1; ld_addr = addr; ld_len = 4'(n); end
         default: begin st_valid = 1'b1; st_addr = addr; st_len = 4'(n); st_data = data; end
      endcase
      @(posedge clk);
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         if (progress == n + 1 || fc_done || ld_done || st_done) begin
            checkOutput("done_vec", {fc_done, ld_done, st_done},
                        (progress == n + 1) ? (3'b100 >> kind) : 3'b000);
            cycles = c;
            fin = 1'b1;
         end else begin
            if (stall_at == progress && stall_left > 0) begin
               rdy = 1'b0;
               stall_left--;
            end else begin
               rdy = ($urandom_range(99) >= 32'(stall_pct));
            end
            io_buffer_full = (io_left > 0);
            if (io_left > 0) io_left--;
            prod = rdy && !(kind == K_STORE && is_io && io_buffer_full && progress < n);
            #1;
            checkOutput("mem_wr", mem_wr, kind == K_STORE && progress < n && prod);
            if (progress < n) checkOutput("mem_a", mem_a, addr + progress);
            if (kind == K_STORE && progress < n && prod) begin
               sh = data >> (8 * progress);
               checkOutput("mem_dout", mem_dout, sh[7:0]);
            end
            @(posedge clk);
            if (prod) progress++;
         end
      end
      if (!fin) checkOutput("done_timeout", 1'b1, 1'b0);
      fc_valid = 1'b0;
      ld_valid = 1'b0;
      st_valid = 1'b0;
      rdy = 1'b1;
      io_buffer_full = 1'b0;
      if (fin && progress == n + 1) begin
         if (kind == K_FETCH) checkOutput("fc_line", fc_line, refLine(addr));
         else if (kind == K_LOAD) checkOutput("ld_data", ld_data, refLoad(addr, n));
         else if (is_io) begin
            checkOutput("io_count", io_q.size(), n);
            for (int i = 0; i < n && io_q.size() > 0; i++) begin
               sh = data >> (8 * i);
               checkOutput("io_byte", io_q.pop_front(), sh[7:0]);
            end
         end else begin
            for (int i = 0; i < n; i++) begin
               sh  = data >> (8 * i);
               idx = 11'((addr + i) & 32'h7ff);
               ref_mem[idx] = sh[7:0];
               checkOutput("st_byte", ram[idx], ref_mem[idx]);
            end
         end
      end
      io_q.delete();
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_clear", {fc_done, ld_done, st_done}, 3'b000);
   endtask

   // Waits for the next done pulse with rdy held high; which = -1 on timeout.
   task automatic waitDone(output int which, input int budget);
      which = -1;
      for (int c = 0; c < budget && which < 0; c++) begin
         @(negedge clk);
         if (fc_done) which = K_FETCH;
         else if (ld_done) which = K_LOAD;
         else if (st_done) which = K_STORE;
      end
      if (which < 0) checkOutput("wait_timeout", 1'b1, 1'b0);
   endtask

   task automatic checkResetOutputs(input string pfx);
      checkOutput({pfx, "_mem_a"}, mem_a, 32'h0);
      checkOutput({pfx, "_mem_wr"}, mem_wr, 1'b0);
      checkOutput({pfx, "_mem_dout"}, mem_dout, 8'h0);
      checkOutput({pfx, "_dones"}, {fc_done, ld_done, st_done}, 3'b000);
      checkOutput({pfx, "_fc_line"}, fc_line, 128'h0);
      checkOutput({pfx, "_ld_data"}, ld_data, 32'h0);
   endtask

   int          cyc;
   int          w;
   int          exp2;
   int          fc_seen;
   bit          st_seen;
   int          kind;
   int          n;
   logic [31:0] addr;
   logic [31:0] data;
   logic [31:0] sh;

   // Directed scenarios first, then a randomized mix of transactions.
   initial begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = initByte(i);
      rst = 1'b1; rdy = 1'b1; rb = 1'b0;
      fc_valid = 1'b0; fc_addr = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_len = '0;
      st_valid = 1'b0; st_addr = '0; st_data = '0; st_len = '0;
      io_buffer_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;

      $display("[TB] fetch line at 0x100");
      applyStimulus(K_FETCH, 32'h100, 16, 32'h0, 0, -1, 0, cyc);
      checkOutput("t1_cycles", cyc, 17);
      checkOutput("t1_line", fc_line, 128'h0F0E0D0C0B0A09080706050403020100);

      $display("[TB] load/fetch tie");
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h200; ld_len = 4'd4;
      fc_valid = 1'b1; fc_addr = 32'h100;
      waitDone(w, 100);
      checkOutput("t2_first", w, K_LOAD);
      checkOutput("t2_ld_data", ld_data, 32'hEFBEADDE);
      waitDone(w, 100);
`ifdef MEM_SCHED_RR_EN
      exp2 = K_FETCH;
`else
      exp2 = K_LOAD;
`endif
      checkOutput("t2_second", w, exp2);
      if (w == K_LOAD) ld_valid = 1'b0;
      else fc_valid = 1'b0;
      waitDone(w, 100);
      checkOutput("t2_third", w, (exp2 == K_LOAD) ? K_FETCH : K_LOAD);
      if (w == K_FETCH) checkOutput("t2_fc_line", fc_line, 128'h0F0E0D0C0B0A09080706050403020100);
      else checkOutput("t2_ld_data2", ld_data, 32'hEFBEADDE);
      ld_valid = 1'b0;
      fc_valid = 1'b0;
      @(posedge clk);

      $display("[TB] UART store with io_buffer_full");
      applyStimulus(K_STORE, 32'h30000, 1, 32'h41, 0, -1, 5, cyc);
      checkOutput("t3_cycles", cyc, 7);

      $display("[TB] rollback mid-fetch with concurrent store");
      @(negedge clk);
      fc_valid = 1'b1; fc_addr = 32'h180;
      @(posedge clk);
      repeat (6) @(posedge clk);
      @(negedge clk);
      fc_valid = 1'b0; rb = 1'b1;
      data = $urandom;
      st_valid = 1'b1; st_addr = 32'h300; st_len = 4'd4; st_data = data;
      @(posedge clk);
      @(negedge clk);
      rb = 1'b0;
      fc_seen = 0;
      st_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (fc_done) fc_seen++;
         if (st_done) begin
            st_seen = 1'b1;
            st_valid = 1'b0;
         end
         @(negedge clk);
      end
      checkOutput("t4_no_fc_done", fc_seen, 0);
      checkOutput("t4_st_done", st_seen, 1'b1);
      for (int i = 0; i < 4; i++) begin
         sh = data >> (8 * i);
         ref_mem[11'h300 + 11'(i)] = sh[7:0];
         checkOutput("t4_st_byte", ram[11'h300 + 11'(i)], sh[7:0]);
      end

      $display("[TB] rdy stall during load");
      applyStimulus(K_LOAD, 32'h204, 2, 32'h0, 0, 1, 0, cyc);
      checkOutput("t5_cycles", cyc, 6);

      $display("[TB] reset during store");
      @(negedge clk);
      st_valid = 1'b1; st_addr = 32'h310; st_len = 4'd4; st_data = 32'h11223344;
      @(posedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      st_valid = 1'b0;
      @(posedge clk);
      #1;
      checkResetOutputs("t6");
      @(negedge clk);
      rst = 1'b0;
      st_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (st_done) st_seen = 1'b1;
      end
      checkOutput("t6_no_st_done", st_seen, 1'b0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 60; t++) begin
         kind = int'($urandom_range(2));
         data = $urandom;
         if (kind == K_FETCH) begin
            addr = {24'h0, 4'($urandom_range(0, 15)), 4'h0} + 32'h100 * $urandom_range(0, 2);
            applyStimulus(K_FETCH, addr, 16, 32'h0, 25, -1, 0, cyc);
         end else begin
            case ($urandom_range(2))
               0:       n = 1;
               1:       n = 2;
               default: n = 4;
            endcase
            if (kind == K_STORE && $urandom_range(3) == 0) begin
               applyStimulus(K_STORE, 32'h30000, 1, data, 25, -1, int'($urandom_range(0, 4)), cyc);
            end else begin
               addr = $urandom_range(0, 32'h2FC);
               applyStimulus(kind, addr, n, data, 25, -1, 0, cyc);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
